// File: rtl/divisor_seq_ctrl.sv
// -----------------------------------------------------------------------------
// divisor_seq_ctrl
//
// Iterative restoring divider controller. Computes Q = A / B and R = A % B for
// N-bit unsigned operands, one quotient bit per clock. The results are
// bit-exact with a combinational divider.
//
// Optional build macro: DIV_ZERO_FAST_EN
//   undefined : div_zero is tied to 0; B == 0 runs the full N steps and the
//               algorithm naturally produces Q = all ones, R = A.
//   defined   : B == 0 skips the N steps. done follows the accepting edge by
//               one cycle, with Q = all ones, R = A and div_zero = 1. Any
//               division with B != 0 clears div_zero when it completes.
//
// Parameters:
//   N          operand/result width in bits (N >= 2)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      division request, sampled only while idle
//   A          dividend, captured on the accepting edge
//   B          divisor, captured on the accepting edge
//   busy       high from the accepting edge until the return to idle
//   done       one-cycle completion pulse
//   Q          quotient, held until the next completion
//   R          remainder, held until the next completion
//   div_zero   divide-by-zero flag (see DIV_ZERO_FAST_EN)
//   state_dbg  current FSM state encoding (0 idle, 1 run, 2 done)
//
// Handshake: start is a request that is accepted on any rising edge where the
// block is idle (busy == 0) and start == 1. A and B are sampled on that same
// edge only. While busy == 1, start is ignored, including in the done cycle.
// done rises for exactly one cycle when the result is ready. Q, R and
// div_zero are valid from that cycle on and hold until the next completion.
// The block does not wait for an acknowledge; done is a pulse, not a level.
// -----------------------------------------------------------------------------
module divisor_seq_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         div_zero,
    output logic [1:0]   state_dbg
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Working registers. The quotient register starts out holding the
    // dividend; its MSBs are shifted into the remainder as quotient bits are
    // shifted in at the LSB end.
    logic [N:0]    rem;
    logic [N-1:0]  quo;
    logic [N-1:0]  div;
    logic [CW-1:0] cnt;

    // One restoring step, computed combinationally from the working registers.
    logic [N:0]   rem_shift;
    logic [N:0]   rem_step;
    logic [N-1:0] quo_step;
    logic         fits;

    logic accept;
    logic last_step;
    logic zero_fast;
    logic finish;

    // -------------------------------------------------------------------------
    // Datapath step
    // -------------------------------------------------------------------------
    always_comb begin
        rem_shift = {rem[N-1:0], quo[N-1]};
        quo_step  = {quo[N-2:0], 1'b0};
        rem_step  = rem_shift;
        // The remainder carries one extra bit, so the compare against the
        // zero-extended divisor cannot overflow.
        fits      = (rem_shift >= {1'b0, div});
        if (fits) begin
            rem_step    = rem_shift - {1'b0, div};
            quo_step[0] = 1'b1;
        end
    end

    assign accept    = (state == ST_IDLE) && start;
    assign last_step = (cnt == CW'(N - 1));

`ifdef DIV_ZERO_FAST_EN
    // A zero divisor leaves on the first run edge. No step has been applied
    // yet, so quo still holds the captured dividend and becomes R.
    assign zero_fast = (div == '0);
`else
    assign zero_fast = 1'b0;
`endif

    assign finish = (state == ST_RUN) && (last_step || zero_fast);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (finish) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here; a held start is
                // accepted on the following idle edge instead.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Working registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            quo <= '0;
            div <= '0;
            cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rem <= '0;
                        quo <= A;
                        div <= B;
                        cnt <= '0;
                    end
                end
                ST_RUN: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    rem <= rem;
                    quo <= quo;
                    div <= div;
                    cnt <= cnt;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Result registers: written only on the edge that enters the done state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= '0;
            R <= '0;
        end else if (finish) begin
            if (zero_fast) begin
                Q <= '1;
                R <= quo;
            end else begin
                Q <= quo_step;
                R <= rem_step[N-1:0];
            end
        end
    end

`ifdef DIV_ZERO_FAST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            div_zero <= 1'b0;
        end else if (finish) begin
            div_zero <= zero_fast;
        end
    end
`else
    assign div_zero = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Status outputs
    // -------------------------------------------------------------------------
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_divisor_seq_ctrl.sv
module tb_divisor_seq_ctrl;

  localparam int N = 4;
  localparam int TIMEOUT = 50;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         div_zero;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  divisor_seq_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (a),
    .B         (b),
    .busy      (busy),
    .done      (done),
    .Q         (q),
    .R         (r),
    .div_zero  (div_zero),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int va, input int vb, input int vq, input int vr);
    vec_t v;
    v.a   = N'(va);
    v.b   = N'(vb);
    v.q   = N'(vq);
    v.r   = N'(vr);
    v.dz  = 1'b0;
    v.lat = N;
`ifdef DIV_ZERO_FAST_EN
    if (vb == 0) begin
      v.dz  = 1'b1;
      v.lat = 1;
    end
`endif
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one division, start pulsed for a single accepting edge.
  // Inputs change on negedge, outputs are sampled on negedge.
  // ---------------------------------------------------------------------------
  task automatic run_div(input vec_t v, input string tag);
    int lat;
    start = 1'b1;
    a     = v.a;
    b     = v.b;
    @(negedge clk);                 // accepting edge has passed
    start = 1'b0;
    a     = ~v.a;                   // late operand changes must not matter
    b     = ~v.b;
    check({tag, " busy_after_accept"}, busy, 1);
    lat = 0;
    while (!done && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    exp_q.push_back(v.q);
    check({tag, " latency"}, lat, v.lat);
    check({tag, " Q"}, q, exp_q.pop_front());
    check({tag, " R"}, r, v.r);
    check({tag, " div_zero"}, div_zero, v.dz);
    check({tag, " busy_in_done"}, busy, 1);
    @(negedge clk);
    check({tag, " done_pulse_width"}, done, 0);
    check({tag, " busy_released"}, busy, 0);
    check({tag, " Q_hold"}, q, v.q);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int cnt;
    int dones;
    logic [N-1:0] q_seen;
    logic [N-1:0] r_seen;

    vecs.push_back(mk(13, 4, 3, 1));
    vecs.push_back(mk(10, 3, 3, 1));
    vecs.push_back(mk(3, 9, 0, 3));
    vecs.push_back(mk(15, 1, 15, 0));
    vecs.push_back(mk(9, 2, 4, 1));
    vecs.push_back(mk(0, 5, 0, 0));
    vecs.push_back(mk(15, 15, 1, 0));
    vecs.push_back(mk(14, 3, 4, 2));
    vecs.push_back(mk(1, 2, 0, 1));
    vecs.push_back(mk(15, 7, 2, 1));
    vecs.push_back(mk(7, 0, 15, 7));
    vecs.push_back(mk(0, 0, 15, 0));

    // Reset held two cycles.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset Q", q, 0);
    check("reset R", r, 0);
    check("reset div_zero", div_zero, 0);
    check("reset state", state_dbg, 0);

    // Table-driven divisions.
    foreach (vecs[i]) begin
      run_div(vecs[i], $sformatf("vec%0d %0d/%0d", i, vecs[i].a, vecs[i].b));
    end

    // Back-to-back with start held high: 10/3 then 3/9.
    start = 1'b1;
    a = 4'd10;
    b = 4'd3;
    @(negedge clk);
    a = 4'd3;
    b = 4'd9;
    cnt = 0;
    while (!done && cnt < TIMEOUT) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b first latency", cnt, N);
    check("b2b first Q", q, 3);
    check("b2b first R", r, 1);
    cnt = 0;
    @(negedge clk);
    cnt++;
    check("b2b idle gap busy", busy, 0);
    check("b2b idle gap Q hold", q, 3);
    check("b2b idle gap R hold", r, 1);
    @(negedge clk);
    cnt++;
    check("b2b second accepted", busy, 1);
    check("b2b Q hold during run", q, 3);
    while (!done && cnt < TIMEOUT) begin
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    check("b2b done spacing", cnt, N + 2);
    check("b2b second Q", q, 0);
    check("b2b second R", r, 3);
    @(negedge clk);

    // start pulses while busy are ignored: 15/1 with 0/5 requests in flight.
    start = 1'b1;
    a = 4'd15;
    b = 4'd1;
    @(negedge clk);
    a = 4'd0;
    b = 4'd5;
    dones = 0;
    q_seen = '0;
    r_seen = '0;
    for (int i = 0; i < 2 * N + 4; i++) begin
      start = busy & i[0];          // pulse only while busy, incl. done cycle
      if (done) begin
        start = 1'b1;               // also try in the done cycle
        dones++;
        q_seen = q;
        r_seen = r;
      end
      @(negedge clk);
      if (!busy) start = 1'b0;
    end
    start = 1'b0;
    check("busy_ignore done count", dones, 1);
    check("busy_ignore Q", q_seen, 15);
    check("busy_ignore R", r_seen, 0);
    check("busy_ignore back idle", busy, 0);

    // Reset in the middle of a 13/4 division.
    start = 1'b1;
    a = 4'd13;
    b = 4'd4;
    @(negedge clk);                 // edge 0 accepted
    start = 1'b0;
    @(negedge clk);                 // edge 1 step
    rst = 1'b1;
    @(negedge clk);                 // edge 2 resets
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst Q", q, 0);
    check("midrst R", r, 0);
    check("midrst div_zero", div_zero, 0);
    check("midrst state", state_dbg, 0);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst no done", dones, 0);
    run_div(mk(9, 2, 4, 1), "after_rst 9/2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
